ava_rx_fifo: RTL and testbench

Avalon-MM responder that lets a bus master read a stream of 32-bit words produced by local logic. A producer pushes words through a valid/ready port into an internal FIFO. The Avalon master drains the FIFO by reading a DATA register and monitors it through STATUS, CONTROL and THRESHOLD registers. The block sits on the same word-addressed slave decode as the ALU slave (ava_address = byte addr[3:2]) and uses a fixed one-wait-state waitrequest handshake.

---
 rtl/ava_rx_fifo_pkg.sv | 24 ++
 rtl/ava_sync_fifo.sv | 58 +++++
 rtl/ava_rx_fifo.sv | 165 ++++++++++++++++
 tb/tb_ava_rx_fifo.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ava_rx_fifo_pkg.sv
// Shared definitions for the ava_rx_fifo Avalon-MM receive FIFO:
// register offsets, STATUS/CONTROL bit positions and the bus handshake states.
package ava_rx_fifo_pkg;

    localparam logic [1:0] REG_DATA      = 2'd0;
    localparam logic [1:0] REG_STATUS    = 2'd1;
    localparam logic [1:0] REG_CONTROL   = 2'd2;
    localparam logic [1:0] REG_THRESHOLD = 2'd3;

    localparam int STAT_EMPTY     = 16;
    localparam int STAT_FULL      = 17;
    localparam int STAT_UNDERFLOW = 18;
    localparam int STAT_IRQ       = 19;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_FLUSH  = 1;
    localparam int CTRL_IRQ_EN = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

endpackage

// File: rtl/ava_sync_fifo.sv
// Synchronous word FIFO with occupancy count and a flush that outranks push/pop.
// Head word is presented combinationally on rd_data.
module ava_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count <= count + (AW+1)'(1);
            end else if (pop_ok && !push_ok) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ava_rx_fifo.sv
// Avalon-MM responder draining a producer-fed FIFO through DATA/STATUS/CONTROL/THRESHOLD.
// Define AVA_RX_FIFO_IRQ_EN to build the THRESHOLD register and the level interrupt.
module ava_rx_fifo
    import ava_rx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ava_chipselect,
    input  logic [1:0]  ava_address,
    input  logic        ava_read,
    input  logic        ava_write,
    input  logic [31:0] ava_writedata,
    input  logic [3:0]  ava_byteenable,
    output logic [31:0] ava_readdata,
    output logic        ava_waitrequest,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        irq
);

    bus_state_t  state;
    logic        access;
    logic        sample;
    logic        complete;
    logic        wr_en;
    logic        enable_q;
    logic        underflow_q;
    logic        pop_pending;
    logic        under_pending;
    logic        fifo_flush;
    logic        fifo_pop;
    logic        fifo_push;
    logic [31:0] head;
    logic [AW:0] count;
    logic        empty;
    logic        full;
    logic        irq_en;
    logic [31:0] threshold_word;
    logic [31:0] status_word;
    logic [31:0] control_word;
    logic [31:0] rd_mux;
    logic        unused_bits;

    assign unused_bits = ^{ava_writedata, ava_byteenable[3:1]};

    assign access          = ava_chipselect & (ava_read | ava_write);
    assign ava_waitrequest = access & (state == ST_IDLE);
    assign sample          = access & (state == ST_IDLE);
    assign complete        = access & (state == ST_ACK);
    assign wr_en           = complete & ava_write & ~ava_read & ava_byteenable[0];

    assign in_ready   = enable_q & ~full;
    assign fifo_push  = in_valid & in_ready;
    assign fifo_pop   = complete & ava_read & pop_pending;
    assign fifo_flush = wr_en & (ava_address == REG_CONTROL) & ava_writedata[CTRL_FLUSH];

    ava_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (fifo_flush),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (in_data),
        .rd_data (head),
        .count   (count),
        .empty   (empty),
        .full    (full)
    );

`ifdef AVA_RX_FIFO_IRQ_EN
    logic        irq_en_q;
    logic [AW:0] threshold_q;
    logic        irq_q;

    assign irq_en         = irq_en_q;
    assign irq            = irq_q;
    assign threshold_word = 32'(threshold_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q    <= 1'b0;
            threshold_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_en && ava_address == REG_CONTROL) begin
                irq_en_q <= ava_writedata[CTRL_IRQ_EN];
            end
            if (wr_en && ava_address == REG_THRESHOLD) begin
                threshold_q <= ava_writedata[AW:0];
            end
            irq_q <= irq_en_q && (threshold_q != '0) && (count >= threshold_q);
        end
    end
`else
    assign irq_en         = 1'b0;
    assign irq            = 1'b0;
    assign threshold_word = '0;
`endif

    always_comb begin
        status_word                 = '0;
        status_word[AW:0]           = count;
        status_word[STAT_EMPTY]     = empty;
        status_word[STAT_FULL]      = full;
        status_word[STAT_UNDERFLOW] = underflow_q;
        status_word[STAT_IRQ]       = irq;
        control_word                = '0;
        control_word[CTRL_ENABLE]   = enable_q;
        control_word[CTRL_IRQ_EN]   = irq_en;
    end

    always_comb begin
        rd_mux = '0;
        case (ava_address)
            REG_DATA:      rd_mux = empty ? 32'd0 : head;
            REG_STATUS:    rd_mux = status_word;
            REG_CONTROL:   rd_mux = control_word;
            REG_THRESHOLD: rd_mux = threshold_word;
            default:       rd_mux = '0;
        endcase
    end

    // Read data and the pop/underflow decision are frozen at the sampling edge so a
    // push arriving during the ACK cycle cannot cause a pop of a word never returned.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            ava_readdata  <= '0;
            enable_q      <= 1'b0;
            underflow_q   <= 1'b0;
            pop_pending   <= 1'b0;
            under_pending <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                if (sample) begin
                    state <= ST_ACK;
                    if (ava_read) begin
                        ava_readdata <= rd_mux;
                    end
                    pop_pending   <= ava_read && (ava_address == REG_DATA) && !empty;
                    under_pending <= ava_read && (ava_address == REG_DATA) && empty;
                end
            end else begin
                state <= ST_IDLE;
            end

            if (wr_en && ava_address == REG_CONTROL) begin
                enable_q <= ava_writedata[CTRL_ENABLE];
            end
            if (wr_en && ava_address == REG_STATUS && ava_writedata[STAT_UNDERFLOW]) begin
                underflow_q <= 1'b0;
            end else if (complete && ava_read && under_pending) begin
                underflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ava_rx_fifo.sv
// Scoreboard bench for ava_rx_fifo: bus reads queue expected data, a negedge monitor checks it.
// Irq checks adapt to whether AVA_RX_FIFO_IRQ_EN is defined.
module tb_ava_rx_fifo;
    import ava_rx_fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ava_chipselect = 1'b0;
    logic [1:0]  ava_address = 2'd0;
    logic        ava_read = 1'b0;
    logic        ava_write = 1'b0;
    logic [31:0] ava_writedata = '0;
    logic [3:0]  ava_byteenable = 4'hF;
    logic [31:0] ava_readdata;
    logic        ava_waitrequest;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        irq;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    ava_rx_fifo #(.DEPTH(16), .AW(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .ava_chipselect  (ava_chipselect),
        .ava_address     (ava_address),
        .ava_read        (ava_read),
        .ava_write       (ava_write),
        .ava_writedata   (ava_writedata),
        .ava_byteenable  (ava_byteenable),
        .ava_readdata    (ava_readdata),
        .ava_waitrequest (ava_waitrequest),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every completed read (ACK cycle, waitrequest low) consumes one expectation.
    logic [31:0] mon_exp;
    string       mon_name;
    always @(negedge clk) begin
        if (!reset && ava_chipselect && ava_read && !ava_waitrequest) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected read: got 0x%08h, expected no read", ava_readdata);
            end else begin
                mon_exp  = exp_q.pop_front();
                mon_name = name_q.pop_front();
                check_output(mon_name, ava_readdata, mon_exp);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completing edge.
    task automatic bus_access(input logic is_rd, input logic [1:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic [31:0] exp, input string name);
        int   waits;
        logic done;
        waits = 0;
        done  = 1'b0;
        if (is_rd) begin
            exp_q.push_back(exp);
            name_q.push_back(name);
        end
        ava_chipselect = 1'b1;
        ava_read       = is_rd;
        ava_write      = !is_rd;
        ava_address    = addr;
        ava_writedata  = wd;
        ava_byteenable = be;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (ava_waitrequest) waits++;
            else done = 1'b1;
        end
        check_output({name, " waitstates"}, 32'(waits), 32'd1);
        @(posedge clk);
        #1;
        ava_chipselect = 1'b0;
        ava_read       = 1'b0;
        ava_write      = 1'b0;
        ava_byteenable = 4'hF;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        bus_access(1'b1, addr, 32'd0, 4'hF, exp, name);
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] wd, input string name);
        bus_access(1'b0, addr, wd, 4'hF, 32'd0, name);
    endtask

    task automatic apply_stimulus(input logic [31:0] d);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        check_output("push accepted", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int accepts;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_output("reset readdata", ava_readdata, 32'd0);
        check_output("reset in_ready", {31'd0, in_ready}, 32'd0);
        check_output("reset irq", {31'd0, irq}, 32'd0);
        check_output("reset waitrequest idle", {31'd0, ava_waitrequest}, 32'd0);
        ava_chipselect = 1'b1;
        ava_read       = 1'b1;
        ava_address    = REG_STATUS;
        @(negedge clk);
        check_output("waitrequest in reset", {31'd0, ava_waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        ava_chipselect = 1'b0;
        ava_read       = 1'b0;
        reset          = 1'b0;

        // Basic push and drain
        bus_write(REG_CONTROL, 32'h1, "ctrl enable");
        @(negedge clk);
        check_output("in_ready enabled", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        apply_stimulus(32'h0123_4567);
        apply_stimulus(32'h0123_4568);
        bus_read(REG_DATA, 32'h0123_4567, "data 0");
        bus_read(REG_DATA, 32'h0123_4568, "data 1");
        bus_read(REG_STATUS, 32'h0001_0000, "status empty");

        // Underflow sticky and W1C
        bus_read(REG_DATA, 32'h0000_0000, "data underflow");
        bus_read(REG_STATUS, 32'h0005_0000, "status underflow set");
        bus_write(REG_STATUS, 32'h0004_0000, "status w1c");
        bus_read(REG_STATUS, 32'h0001_0000, "status underflow clear");

        // Fill to full (pointers start at 2, so this wraps), then drain
        accepts  = 0;
        in_valid = 1'b1;
        in_data  = 32'hA000_0000;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) accepts++;
            @(posedge clk);
            #1;
            in_data = 32'hA000_0000 + 32'(accepts);
        end
        in_valid = 1'b0;
        check_output("fill accepts", 32'(accepts), 32'd16);
        @(negedge clk);
        check_output("in_ready full", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        bus_read(REG_STATUS, 32'h0002_0010, "status full");
        for (int i = 0; i < 16; i++) bus_read(REG_DATA, 32'hA000_0000 + 32'(i), "drain A");
        for (int i = 0; i < 16; i++) apply_stimulus(32'hB000_0000 + 32'(i));
        bus_read(REG_STATUS, 32'h0002_0010, "status refill");
        for (int i = 0; i < 16; i++) bus_read(REG_DATA, 32'hB000_0000 + 32'(i), "drain B");
        bus_read(REG_STATUS, 32'h0001_0000, "status drained");

        // Push on the same edge as a DATA pop
        for (int i = 0; i < 5; i++) apply_stimulus(32'hC000_0000 + 32'(i));
        fork
            bus_read(REG_DATA, 32'hC000_0000, "pushpop data");
            begin
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                in_data  = 32'hC000_0005;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        join
        bus_read(REG_STATUS, 32'h0000_0005, "status pushpop");
        for (int i = 1; i < 6; i++) bus_read(REG_DATA, 32'hC000_0000 + 32'(i), "pushpop order");

        // Flush beats a same-edge push
        for (int i = 0; i < 8; i++) apply_stimulus(32'hD000_0000 + 32'(i));
        bus_read(REG_STATUS, 32'h0000_0008, "status 8 queued");
        fork
            bus_write(REG_CONTROL, 32'h3, "ctrl flush");
            begin
                @(posedge clk);
                #1;
                in_valid = 1'b1;
                in_data  = 32'hDDDD_DDDD;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
        join
        bus_read(REG_STATUS, 32'h0001_0000, "status flushed");
        bus_read(REG_CONTROL, 32'h0000_0001, "ctrl flush self-clear");
        apply_stimulus(32'hE000_0000);
        bus_read(REG_DATA, 32'hE000_0000, "data after flush");

        // Register write without byte lane 0 is ignored
        bus_access(1'b0, REG_CONTROL, 32'h0, 4'b1110, 32'd0, "ctrl be ignored");
        bus_read(REG_CONTROL, 32'h0000_0001, "ctrl after be");

        // Threshold interrupt
        bus_write(REG_THRESHOLD, 32'h4, "threshold 4");
        bus_write(REG_CONTROL, 32'h5, "ctrl irq_en");
`ifdef AVA_RX_FIFO_IRQ_EN
        bus_read(REG_THRESHOLD, 32'h0000_0004, "threshold readback");
        bus_read(REG_CONTROL, 32'h0000_0005, "ctrl readback");
        for (int i = 0; i < 4; i++) apply_stimulus(32'hF000_0000 + 32'(i));
        @(negedge clk);
        check_output("irq lags count", {31'd0, irq}, 32'd0);
        @(negedge clk);
        check_output("irq raised", {31'd0, irq}, 32'd1);
        @(posedge clk);
        #1;
        bus_read(REG_STATUS, 32'h0008_0004, "status irq pending");
        bus_read(REG_DATA, 32'hF000_0000, "data irq");
        @(negedge clk);
        check_output("irq held one cycle", {31'd0, irq}, 32'd1);
        @(negedge clk);
        check_output("irq dropped", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
`else
        bus_read(REG_THRESHOLD, 32'h0000_0000, "threshold reads 0");
        bus_read(REG_CONTROL, 32'h0000_0001, "ctrl irq_en absent");
        for (int i = 0; i < 4; i++) apply_stimulus(32'hF000_0000 + 32'(i));
        repeat (3) @(negedge clk);
        check_output("irq tied low", {31'd0, irq}, 32'd0);
        @(posedge clk);
        #1;
        bus_read(REG_STATUS, 32'h0000_0004, "status no irq");
`endif

        // Reset in the middle of an access aborts it
        ava_chipselect = 1'b1;
        ava_read       = 1'b1;
        ava_address    = REG_STATUS;
        @(negedge clk);
        check_output("abort waitrequest first", {31'd0, ava_waitrequest}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("abort waitrequest again", {31'd0, ava_waitrequest}, 32'd1);
        check_output("abort readdata", ava_readdata, 32'd0);
        check_output("abort in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        ava_chipselect = 1'b0;
        ava_read       = 1'b0;
        reset          = 1'b0;
        bus_read(REG_STATUS, 32'h0001_0000, "status after reset");
        bus_read(REG_CONTROL, 32'h0000_0000, "ctrl after reset");

        repeat (2) @(posedge clk);
        check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
